coin_acceptor: RTL and testbench
================================

# coin_acceptor

Upstream front end of the vending controller. Turns the two raw, bouncy coin-sensor lines (5 rs and 10 rs) into clean, single-cycle `coin_in` codes for the vending FSM. It synchronizes and debounces each line and rejects invalid or blocked coins. Accepted coins are queued in a small FIFO and emitted one per slot, with a guaranteed idle gap between slots.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples needed to change a debounced level (≥1).
- FIFO_DEPTH, 4: accepted-coin queue depth (power of two, ≥2).
- GAP_CYCLES, 1: cycles of `coin_in`=00 forced after each emitted code (≥0).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sense_5  in  1  raw 5 rs sensor, asynchronous to clk, high while coin present.
- sense_10  in  1  raw 10 rs sensor, same as above.
- accept_en  in  1  high = coins accepted. Low = coins rejected.
- hold  in  1  downstream stall. While high, no new code starts.
- coin_in  out  2  00 none, 01 5 rs, 10 10 rs. Registered, one cycle per coin.
- reject  out  1  one-cycle pulse per rejected coin.
- overflow  out  1  sticky flag, set when a coin is lost to a full FIFO. Cleared only by reset.

## Operation
- Each sense line passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: counter reloads whenever the synchronized sample equals the debounced level. The debounced level flips after DEBOUNCE_CYCLES consecutive differing samples.
- Coin event = rising edge of a debounced level. Falling edges produce nothing.
- Classification, in the cycle of the event:
  - Both debounced levels high → reject pulse, nothing queued. This covers simultaneous rises.
  - accept_en=0 → reject pulse, nothing queued.
  - FIFO full → reject pulse, overflow set, nothing queued.
  - Otherwise → push coin type (1 bit: 0=5, 1=10) into the FIFO.
- Output FSM states:
  - IDLE → EMIT when the FIFO is non-empty and hold=0. The pop happens on this transition.
  - EMIT: `coin_in` = popped code for exactly one cycle. Then → GAP, or → IDLE if GAP_CYCLES=0.
  - GAP: `coin_in`=00 for GAP_CYCLES cycles → IDLE.
- hold only blocks the IDLE→EMIT transition. A code already in EMIT completes.
- Push and pop in the same cycle are legal, including when the FIFO is full (push accepted). Pointers wrap modulo FIFO_DEPTH.
- `coin_in` never carries 11.

## Timing
- Reset values: `coin_in`=00, reject=0, overflow=0. FIFO empty, debounced levels 0, counters 0, FSM IDLE.
- Reset is asynchronous: asserting rst_n mid-EMIT drops `coin_in` to 00 immediately, and queued coins are discarded.
- Latency, with the FIFO empty, FSM in IDLE and hold=0: raw line goes high before edge E0 and stays stable → `coin_in` is valid in the cycle after edge E0+DEBOUNCE_CYCLES+3. The cycles break down as:
  - 2 synchronizer cycles
  - DEBOUNCE_CYCLES debounce cycles
  - 1 push cycle
  - 1 output register cycle
- reject asserts in the cycle after the debounced edge, at the same point where a push would occur.
- Sustained throughput: at most one code per 1+GAP_CYCLES cycles.

## Structure
- Shared package `vending_pkg`:
  - Coin code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10, also used by the vending FSM.
  - Output FSM state enum (IDLE, EMIT, GAP).
- Sub-module `coin_debounce` (synchronizer + debouncer + rising-edge detect), instantiated once per sense line.
- FIFO and output FSM are inline.

## Test plan
- sense_5 held high 20 cycles, defaults → single `coin_in`=01 pulse in the cycle after E7. No further pulses; reject=0.
- sense_10 toggling every 2 cycles for 10 cycles, then steady high → exactly one `coin_in`=10 pulse. Falling edge produces nothing.
- Coins 5, 10, 5 (each high 6 cycles, low 6 cycles) with hold=1 throughout, then hold released → 01, 10, 01 in order. Each pulse is one cycle, separated by exactly one 00 cycle.
- hold=1, six valid coins, FIFO_DEPTH=4 → coins 5 and 6 each give a reject pulse and overflow=1. Releasing hold yields exactly four codes. overflow stays 1 until rst_n is pulsed.
- Both sensors rising in the same cycle, and separately one coin with accept_en=0 → one reject pulse each, `coin_in` stays 00, FIFO count unchanged.
- rst_n asserted during EMIT with two coins queued → `coin_in`=00 immediately, all outputs at reset values. No codes emitted after release without new coins.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared definitions for the vending front end and controller:
// coin codes on the coin_in bus and the coin_acceptor output FSM states.
package vending_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      GAP  = 2'd2
   } out_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin sense line: 2-flop synchronizer, counting debouncer and
// rising-edge detect on the debounced level.
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sense,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_reg;
   logic          sync_reg;
   logic          level_reg;
   logic          level_d_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg    <= 1'b0;
         sync_reg    <= 1'b0;
         level_reg   <= 1'b0;
         level_d_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         meta_reg    <= sense;
         sync_reg    <= meta_reg;
         level_d_reg <= level_reg;
         // Any sample agreeing with the current level restarts the count.
         if (sync_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            level_reg <= sync_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign level = level_reg;
   assign rise  = level_reg & ~level_d_reg;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces both sense lines, classifies coin events,
// queues accepted coins and emits them as single-cycle coin_in codes.
module coin_acceptor
   import vending_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int GAP_CYCLES      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sense_5,
   input  logic       sense_10,
   input  logic       accept_en,
   input  logic       hold,
   output logic [1:0] coin_in,
   output logic       reject,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // Index 0 = 5 rs line, index 1 = 10 rs line.
   logic [1:0] sense_vec;
   logic [1:0] level;
   logic [1:0] rise;

   assign sense_vec = {sense_10, sense_5};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .sense (sense_vec[gi]),
            .level (level[gi]),
            .rise  (rise[gi])
         );
      end
   endgenerate

   logic          fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          fifo_empty;
   logic          fifo_full;

   out_state_t    state_reg, state_next;
   logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
   logic [1:0]    coin_reg, coin_next;
   logic          reject_reg;
   logic          overflow_reg;
   logic          can_start;
   logic          pop;

   logic          coin_event;
   logic          both_high;
   logic          blocked;
   logic          push;
   logic          overflow_set;

   assign fifo_empty   = (count_reg == '0);
   assign fifo_full    = (count_reg == CW'(FIFO_DEPTH));
   assign coin_event   = |rise;
   assign both_high    = &level;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign blocked      = fifo_full & ~pop;
   assign push         = coin_event & ~both_high & accept_en & ~blocked;
   assign overflow_set = coin_event & ~both_high & accept_en & blocked;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= rise[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         state_reg    <= IDLE;
         gap_cnt_reg  <= '0;
         coin_reg     <= COIN_NONE;
         reject_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_reg + AW'(push);
         rd_ptr_reg   <= rd_ptr_reg + AW'(pop);
         count_reg    <= count_reg + CW'(push) - CW'(pop);
         state_reg    <= state_next;
         gap_cnt_reg  <= gap_cnt_next;
         coin_reg     <= coin_next;
         reject_reg   <= coin_event & ~push;
         overflow_reg <= overflow_reg | overflow_set;
      end
   end

   // The last idle cycle of a code slot may launch the next code directly,
   // so back-to-back codes are separated by exactly GAP_CYCLES zero cycles.
   always_comb begin
      state_next   = state_reg;
      gap_cnt_next = gap_cnt_reg;
      coin_next    = COIN_NONE;
      pop          = 1'b0;
      can_start    = 1'b0;
      case (state_reg)
         IDLE: can_start = 1'b1;
         EMIT: begin
            if (GAP_CYCLES == 0) begin
               state_next = IDLE;
               can_start  = 1'b1;
            end else begin
               state_next   = GAP;
               gap_cnt_next = '0;
            end
         end
         GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = IDLE;
               can_start  = 1'b1;
            end else begin
               gap_cnt_next = gap_cnt_reg + GW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
      if (can_start && !fifo_empty && !hold) begin
         pop        = 1'b1;
         state_next = EMIT;
         coin_next  = fifo_mem[rd_ptr_reg] ? COIN_10 : COIN_5;
      end
   end

   assign coin_in  = coin_reg;
   assign reject   = reject_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: directed coin sequences push expected
// codes/rejects, a negedge monitor pops and compares what the DUT presents.
module tb_coin_acceptor;
   import vending_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sense_5 = 1'b0;
   logic       sense_10 = 1'b0;
   logic       accept_en = 1'b1;
   logic       hold = 1'b0;
   logic [1:0] coin_in;
   logic       reject;
   logic       overflow;

   always #5 clk = ~clk;

   coin_acceptor #(
      .DEBOUNCE_CYCLES (4),
      .FIFO_DEPTH      (4),
      .GAP_CYCLES      (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sense_5   (sense_5),
      .sense_10  (sense_10),
      .accept_en (accept_en),
      .hold      (hold),
      .coin_in   (coin_in),
      .reject    (reject),
      .overflow  (overflow)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] code;
      int         at_cyc;   // required cycle number, -1 = don't care
      int         delta;    // required distance from previous code, -1 = don't care
   } exp_t;

   exp_t exp_q[$];
   int   rej_pending = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   last_cyc = -100;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] code, input int at_cyc, input int delta);
      exp_t e;
      e.code   = code;
      e.at_cyc = at_cyc;
      e.delta  = delta;
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (coin_in != COIN_NONE) begin
            $display("tx: coin_in=%b at cycle %0d", coin_in, cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_code: got %b, expected none", coin_in);
            end else begin
               e = exp_q.pop_front();
               check("code", coin_in, e.code);
               if (e.at_cyc >= 0) check("latency", cyc, e.at_cyc);
               if (e.delta >= 0) check("spacing", cyc - last_cyc, e.delta);
            end
            last_cyc = cyc;
         end
         if (reject) begin
            $display("tx: reject at cycle %0d", cyc);
            n_checks++;
            if (rej_pending == 0) begin
               n_fail++;
               $display("FAIL unexpected_reject: got 1, expected 0");
            end else begin
               rej_pending--;
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic coin(input bit ten, input int hi, input int lo);
      @(negedge clk);
      if (ten) sense_10 = 1'b1;
      else     sense_5  = 1'b1;
      cycles(hi);
      sense_5  = 1'b0;
      sense_10 = 1'b0;
      cycles(lo);
   endtask

   task automatic drain(input string name, input int budget);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || rej_pending != 0) && i < budget) begin
         @(negedge clk);
         i++;
      end
      cycles(20);
      check({name, "_codes_left"}, exp_q.size(), 0);
      check({name, "_rejects_left"}, rej_pending, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  k;
      bit  found;

      // Reset state
      #1;
      check("rst_coin_in", coin_in, COIN_NONE);
      check("rst_reject", reject, 0);
      check("rst_overflow", overflow, 0);
      cycles(3);
      rst_n = 1'b1;
      cycles(2);
      check("post_rst_coin_in", coin_in, COIN_NONE);

      // Single 5 rs coin, latency: valid in the cycle after E0+7
      @(negedge clk);
      k = cyc;
      sense_5 = 1'b1;
      exp_q.push_back(mk(COIN_5, k + 8, -1));
      cycles(20);
      sense_5 = 1'b0;
      drain("single5", 60);

      // Bouncing 10 rs line, then steady high
      exp_q.push_back(mk(COIN_10, -1, -1));
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         sense_10 = (i % 2 == 0);
         cycles(2);
      end
      cycles(18);
      sense_10 = 1'b0;
      drain("bounce10", 60);

      // Three coins queued under hold, released in order
      hold = 1'b1;
      exp_q.push_back(mk(COIN_5, -1, -1));
      exp_q.push_back(mk(COIN_10, -1, 2));
      exp_q.push_back(mk(COIN_5, -1, 2));
      coin(1'b0, 6, 6);
      coin(1'b1, 6, 6);
      coin(1'b0, 6, 6);
      cycles(4);
      hold = 1'b0;
      drain("hold3", 60);

      // Six coins into a four-deep FIFO under hold
      hold = 1'b1;
      exp_q.push_back(mk(COIN_5, -1, -1));
      exp_q.push_back(mk(COIN_10, -1, 2));
      exp_q.push_back(mk(COIN_5, -1, 2));
      exp_q.push_back(mk(COIN_10, -1, 2));
      rej_pending += 2;
      for (int i = 0; i < 6; i++) coin(i[0], 6, 6);
      cycles(4);
      check("overflow_set", overflow, 1);
      hold = 1'b0;
      drain("overflow6", 80);
      check("overflow_sticky", overflow, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("overflow_cleared", overflow, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);
      check("overflow_after_rst", overflow, 0);

      // Simultaneous rise, then accept_en=0; FIFO must stay empty
      @(negedge clk);
      rej_pending++;
      sense_5  = 1'b1;
      sense_10 = 1'b1;
      cycles(8);
      sense_5  = 1'b0;
      sense_10 = 1'b0;
      cycles(10);
      accept_en = 1'b0;
      rej_pending++;
      coin(1'b1, 6, 6);
      accept_en = 1'b1;
      drain("rejects", 40);
      exp_q.push_back(mk(COIN_5, -1, -1));
      coin(1'b0, 6, 6);
      drain("after_rejects", 40);
      check("no_overflow_from_rejects", overflow, 0);

      // Reset in the middle of EMIT with two coins still queued
      hold = 1'b1;
      coin(1'b0, 6, 6);
      coin(1'b1, 6, 6);
      coin(1'b0, 6, 6);
      @(negedge clk);
      hold = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (coin_in != COIN_NONE) begin
            found = 1'b1;
            break;
         end
      end
      check("emit_seen", found, 1);
      check("emit_code", coin_in, COIN_5);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_coin_in", coin_in, COIN_NONE);
      check("async_rst_reject", reject, 0);
      check("async_rst_overflow", overflow, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(40);
      check("discarded_queue", coin_in, COIN_NONE);
      check("discarded_scoreboard", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
